// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign correction applied in FIX.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             write_hi,
    input  logic             write_lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W2 = 2 * WIDTH;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W2-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    // One multiply or divide iteration on the accumulator.
    logic [WIDTH:0]  mul_sum;
    logic [WIDTH:0]  rem_sh;
    logic [WIDTH:0]  diff;
    logic [W2-1:0]   step;

    always_comb begin
        mul_sum = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        rem_sh  = acc_q[W2-1:WIDTH-1];
        diff    = rem_sh - {1'b0, opb_q};
        if (op_q[1]) begin
            // A clear borrow bit means the trial subtraction fits.
            step = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};
        end else begin
            step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Sign correction: full-width negation serves MULT and the DIV quotient.
    logic [W2-1:0]    neg_full;
    logic [WIDTH-1:0] rem_neg;

    always_comb begin
        neg_full = -acc_q;
        rem_neg  = -acc_q[W2-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (write_hi) hi_d = operand_a;
                if (write_lo) lo_d = operand_a;
                if (start) begin
                    op_d     = op_e'(op);
                    sign_a_d = op[0] & operand_a[WIDTH-1];
                    sign_b_d = op[0] & operand_b[WIDTH-1];
                    acc_d    = {{WIDTH{1'b0}}, magnitude(operand_a, op[0])};
                    opb_d    = magnitude(operand_b, op[0]);
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                unique case (op_q)
                    OP_MULTU: {hi_d, lo_d} = acc_q;
                    OP_MULT:  {hi_d, lo_d} = (sign_a_q ^ sign_b_q) ? neg_full : acc_q;
                    OP_DIVU: begin
                        hi_d = acc_q[W2-1:WIDTH];
                        lo_d = acc_q[WIDTH-1:0];
                    end
                    OP_DIV: begin
                        hi_d = sign_a_q ? rem_neg : acc_q[W2-1:WIDTH];
                        lo_d = (sign_a_q ^ sign_b_q) ? neg_full[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    end
                    default: ;
                endcase
                // With a zero divisor the remainder path has shifted in |a|,
                // so the sign-corrected hi already equals the original dividend.
                if (op_q[1] && opb_q == '0) begin
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clock) begin
        op_q     <= op_d;
        sign_a_q <= sign_a_d;
        sign_b_q <= sign_b_d;
        acc_q    <= acc_d;
        opb_q    <= opb_d;
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic model.
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        rst, start, write_hi, write_lo;
    logic [1:0]  op;
    logic [31:0] operand_a, operand_b;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock       (clock),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .write_hi    (write_hi),
        .write_lo    (write_lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference results straight from integer arithmetic.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] rh, output logic [31:0] rl, output logic rz);
        longint      sa, sb, q, r;
        logic [63:0] p;
        rz = 1'b0;
        rh = '0;
        rl = '0;
        case (o)
            2'b00: begin
                p  = {32'b0, a} * {32'b0, b};
                rh = p[63:32];
                rl = p[31:0];
            end
            2'b01: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                rh = p[63:32];
                rl = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    rz = 1'b1;
                    rl = 32'hFFFF_FFFF;
                    rh = a;
                end else begin
                    if (o == 2'b10) begin
                        sa = longint'({32'b0, a});
                        sb = longint'({32'b0, b});
                    end else begin
                        sa = longint'($signed(a));
                        sb = longint'($signed(b));
                    end
                    q  = sa / sb;
                    r  = sa % sb;
                    rl = q[31:0];
                    rh = r[31:0];
                end
            end
        endcase
    endfunction

    // Called at #1 after an edge with busy=0; returns at #1 after the done edge.
    // disturb: 1 = pulse start mid-op, 2 = write_hi mid-op.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int disturb);
        logic [31:0] eh, el;
        logic        ez;
        int          n, early;
        bit          seen;
        model(o, a, b, eh, el, ez);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("busy_start", {63'b0, busy}, 64'd1);
        check("done_pulse", {62'b0, done, div_by_zero}, 64'd0);
        n = 0; early = 0; seen = 0;
        while (n < 40 && !seen) begin
            if (n == 10 && disturb == 1) begin
                start = 1'b1; op = ~o; operand_a = ~a; operand_b = b + 32'd1;
            end
            if (n == 10 && disturb == 2) begin
                write_hi = 1'b1; operand_a = 32'h5A5A_5A5A;
            end
            @(posedge clock); #1;
            n++;
            start = 1'b0; write_hi = 1'b0;
            if (disturb == 2 && n == 11) check("hi_held_busy", {32'b0, hi}, {32'b0, m_hi});
            if (done) seen = 1;
            else if (!busy) early++;
        end
        check("latency", 64'(n), 64'd33);
        check("busy_span", 64'(early), 64'd0);
        check("busy_done", {63'b0, busy}, 64'd0);
        check("dbz", {63'b0, div_by_zero}, {63'b0, ez});
        check("hilo", {hi, lo}, {eh, el});
        m_hi = eh;
        m_lo = el;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] edges [5];
        edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        case ($urandom_range(0, 3))
            0:       return edges[$urandom_range(0, 4)];
            1:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
        op = 2'b00; operand_a = '0; operand_b = '0;
        repeat (2) @(posedge clock);
        #1;
        rst = 1'b0;
        check("rst_ctl", {61'b0, busy, done, div_by_zero}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 0);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 0);
        run_op(2'b10, 32'd100, 32'd7, 0);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'b10, 32'h1234_5678, 32'h0, 0);
        run_op(2'b11, 32'hFFFF_FFFB, 32'h0, 0);
        run_op(2'b00, 32'h0000_1234, 32'h0000_5678, 1);
        run_op(2'b11, 32'h7FFF_FFFF, 32'hFFFF_FFF0, 2);

        @(posedge clock); #1;
        check("idle_done_low", {62'b0, done, div_by_zero}, 64'd0);
        operand_a = 32'hCAFE_BABE; write_lo = 1'b1;
        @(posedge clock); #1;
        write_lo = 1'b0;
        check("mtlo_lo", {32'b0, lo}, 64'h0000_0000_CAFE_BABE);
        check("mtlo_hi", {32'b0, hi}, {32'b0, m_hi});
        m_lo = 32'hCAFE_BABE;
        operand_a = 32'h0BAD_F00D; write_hi = 1'b1;
        @(posedge clock); #1;
        write_hi = 1'b0;
        check("mthi", {hi, lo}, {32'h0BAD_F00D, m_lo});
        m_hi = 32'h0BAD_F00D;

        op = 2'b00; operand_a = 32'hDEAD_BEEF; operand_b = 32'h1234_5678; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        rst = 1'b1;
        @(posedge clock); #1;
        rst = 1'b0;
        check("abort_ctl", {61'b0, busy, done, div_by_zero}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        m_hi = '0; m_lo = '0;
        run_op(2'b00, 32'd2, 32'd3, 0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock); #1;
            end
            run_op(2'($urandom_range(0, 3)), pick(), pick(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two register-file read values (outputA -> operand_a, outputB -> operand_b).
- Produces a 64-bit result in HI/LO for MULT/MULTU/DIV/DIVU.
- Also supports MTHI/MTLO direct writes.
- The pipeline stalls on busy; MFHI/MFLO results (hi/lo) return through the normal write-back path.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH each; the product is 2*WIDTH.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clock  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request an operation; sampled only when busy=0
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
operand_a  input  WIDTH  multiplicand / dividend (register-file outputA)
operand_b  input  WIDTH  multiplier / divisor (register-file outputB)
write_hi  input  1  MTHI: load hi from operand_a
write_lo  input  1  MTLO: load lo from operand_a
busy  output  1  operation in progress; upstream must stall
done  output  1  one-cycle pulse when hi/lo carry a new result
div_by_zero  output  1  pulses together with done when a divide had operand_b=0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: state IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0. Reset mid-operation aborts immediately and the result is discarded.
- States:
  - IDLE: start=1 -> RUN. At this edge, latch op, the sign flags and |a|, |b| (absolute values for signed ops only); clear the accumulator; counter=0.
  - RUN: one iteration per cycle; counter increments. After the WIDTH-th iteration (counter=WIDTH-1) -> FIX.
  - FIX: apply sign correction. At this edge write hi/lo, assert done (and div_by_zero if applicable) for exactly one cycle, then -> IDLE.
- Latency: start sampled at edge E0. busy=1 from E0 through the FIX edge, i.e. WIDTH+1 cycles (33). hi/lo update and done=1 appear after edge E0+WIDTH+1; busy=0 in that same cycle.
- start while busy=1: ignored, with no queuing. start in the cycle where done=1 is accepted (busy is already 0).
- Multiply: shift-add, unsigned, on magnitudes; {hi,lo} = product.
  - MULT: negate the 2*WIDTH product if sign_a XOR sign_b.
  - 0x80000000 magnitude is handled as unsigned 0x80000000, so no overflow occurs.
- Divide: restoring, one quotient bit per cycle; lo = quotient, hi = remainder.
  - DIV: quotient negated if the signs differ; remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, no flag.
- Divide by zero (operand_b=0): full latency still applies. Result lo=0xFFFFFFFF, hi=operand_a (original, unmodified), div_by_zero=1 with done. Applies to both DIV and DIVU.
- write_hi/write_lo:
  - Honoured only when busy=0 and not in the FIX edge. The register loads operand_a at the next edge.
  - Ignored while busy.
  - If write_* and start occur in the same IDLE cycle, the write applies now and the later result overwrites it.
- hi/lo hold their values between operations. done and div_by_zero are 0 at all times other than the result pulse.
- Undefined op values do not exist (2-bit encoding is complete).

Decomposition:
- Shared package muldiv_pkg:
  - op encodings OP_MULTU/OP_MULT/OP_DIVU/OP_DIV;
  - state encodings ST_IDLE/ST_RUN/ST_FIX;
  - WIDTH default constant.
- No sub-module. Single module containing:
  - FSM;
  - 2*WIDTH accumulator;
  - WIDTH-bit divisor/multiplier register;
  - sign flags;
  - a shared 2*WIDTH negator used in FIX.

Test Plan:
1. Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy for 33 cycles; done one cycle; hi=0xFFFFFFFE, lo=0x00000001.
2. MULT a=0xFFFFFFFD (-3) b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); MULT a=0x80000000 b=0x80000000 -> hi=0x40000000, lo=0.
3. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100 b=7 -> lo=14, hi=2; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIVU a=0x12345678 b=0 -> after 33 cycles done=1, div_by_zero=1, lo=0xFFFFFFFF, hi=0x12345678.
5. start pulsed mid-operation with different operands -> ignored, original result unchanged. write_hi while busy -> hi unchanged. write_lo a=0xCAFEBABE when idle -> lo=0xCAFEBABE next cycle, hi unchanged.
6. rst asserted at cycle 10 of a MULTU -> next cycle busy=0, done=0, hi=lo=0; a new start right after reset completes correctly (2*3 -> lo=6, hi=0).
